// File: rtl/seg7_scan_controller.sv
// Multiplexed N-digit common-anode 7-segment scan controller with per-slot blank guard
// and frame-atomic commit of shadowed display data.
module seg7_scan_controller #(
  parameter int CLK_HZ       = 25000000,
  parameter int SCAN_HZ      = 1000,
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]   wr_dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [31:0]   BLANK_END = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0]   SLOT_END  = 32'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [31:0]           count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic [4*N_DIGITS-1:0] active_data_q, active_data_d;
  logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_q, frame_start_d;
  logic                  boundary;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        idx_d   = '0;
        if (enable) begin
          state_d  = BLANK;
          boundary = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
          idx_d   = '0;
        end else begin
          count_d = count_q + 32'd1;
          if (count_q == BLANK_END) state_d = SHOW;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
          idx_d   = '0;
        end else if (count_q == SLOT_END) begin
          state_d  = BLANK;
          count_d  = '0;
          boundary = (idx_q == LAST_IDX);
          idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        idx_d   = '0;
      end
    endcase

    // Accept and commit are mutually exclusive: commit needs pending, accept needs !pending.
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    if (wr_valid && !pending_q) begin
      shadow_data_d = wr_data;
      shadow_dp_d   = wr_dp;
      pending_d     = 1'b1;
    end
    if (boundary && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
    end

    // Outputs are computed from next-state values so they register on the same edge.
    an_d          = '1;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    frame_start_d = boundary;
    if (state_d == SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = decode(active_data_d[{idx_d, 2'b00} +: 4]);
      dp_d        = ~active_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign wr_ready    = ~pending_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: TICK_DIV=10, 4 digits, 2 blank cycles per slot.
module tb_seg7_scan_controller;

  localparam int NB = 2;
  localparam int TD = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int nvec = 0;
  int nerr = 0;

  seg7_scan_controller #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .N_DIGITS(4),
    .BLANK_CYCLES(NB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_dp(wr_dp),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; if wr_valid was high into this edge, check backpressure and release it.
  task automatic cyc(input logic [3:0] ean, input logic [6:0] eseg, input logic edp,
                     input logic efs);
    logic was_valid;
    was_valid = wr_valid;
    @(negedge clk);
    chk("an", {28'd0, an}, {28'd0, ean});
    chk("seg", {25'd0, seg}, {25'd0, eseg});
    chk("dp", {31'd0, dp}, {31'd0, edp});
    chk("frame_start", {31'd0, frame_start}, {31'd0, efs});
    if (was_valid) begin
      chk("wr_ready_after_valid", {31'd0, wr_ready}, 32'd0);
      wr_valid = 1'b0;
    end
  endtask

  task automatic slot(input int d, input logic [6:0] s, input logic dpv, input logic fs,
                      input int ncyc, input int wr_at, input logic [15:0] wd,
                      input logic [3:0] wdp);
    logic [3:0] m;
    m = 4'b0001 << d;
    m = ~m;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0)       cyc(4'hF, 7'h7F, 1'b1, fs);
      else if (c < NB)  cyc(4'hF, 7'h7F, 1'b1, 1'b0);
      else              cyc(m, s, dpv, 1'b0);
      if (c == wr_at) begin
        wr_valid = 1'b1;
        wr_data  = wd;
        wr_dp    = wdp;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, 7'h7F, 1'b1, 1'b0);
      chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    end
    rst = 1'b0;

    // Load 4321 while idle, then enable.
    wr_valid = 1'b1; wr_data = 16'h4321; wr_dp = 4'b0001;
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
    enable = 1'b1;

    // Frame 1: 4321, dp lit on digit 0 only.
    slot(0, 7'h79, 1'b0, 1'b1, TD, -1, 16'h0, 4'h0);
    chk("ready_after_commit1", {31'd0, wr_ready}, 32'd1);
    slot(1, 7'h24, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(2, 7'h30, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(3, 7'h19, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);

    // Frame 2: write FA80 mid-frame, then an ignored 1111 under backpressure.
    slot(0, 7'h79, 1'b0, 1'b1, TD, -1, 16'h0, 4'h0);
    slot(1, 7'h24, 1'b1, 1'b0, TD, 3, 16'hFA80, 4'b0000);
    slot(2, 7'h30, 1'b1, 1'b0, TD, 3, 16'h1111, 4'b1111);
    chk("ready_while_pending", {31'd0, wr_ready}, 32'd0);
    slot(3, 7'h19, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);

    // Frame 3: FA80; a write lands on the closing boundary edge.
    slot(0, 7'h40, 1'b1, 1'b1, TD, -1, 16'h0, 4'h0);
    chk("ready_after_commit2", {31'd0, wr_ready}, 32'd1);
    slot(1, 7'h00, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(2, 7'h08, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(3, 7'h0E, 1'b1, 1'b0, TD, 9, 16'h5678, 4'b1111);

    // Frame 4: still FA80, 5678 is pending.
    slot(0, 7'h40, 1'b1, 1'b1, TD, -1, 16'h0, 4'h0);
    chk("ready_pending_boundary", {31'd0, wr_ready}, 32'd0);
    slot(1, 7'h00, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(2, 7'h08, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(3, 7'h0E, 1'b1, 1'b0, TD, -1, 16'h0, 4'h0);

    // Frame 5: 5678 with all decimal points lit.
    slot(0, 7'h00, 1'b0, 1'b1, TD, -1, 16'h0, 4'h0);
    slot(1, 7'h78, 1'b0, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(2, 7'h02, 1'b0, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(3, 7'h12, 1'b0, 1'b0, TD, -1, 16'h0, 4'h0);

    // Frame 6: drop enable while digit 2 is lit, then re-enable.
    slot(0, 7'h00, 1'b0, 1'b1, TD, -1, 16'h0, 4'h0);
    slot(1, 7'h78, 1'b0, 1'b0, TD, -1, 16'h0, 4'h0);
    slot(2, 7'h02, 1'b0, 1'b0, 5, -1, 16'h0, 4'h0);
    enable = 1'b0;
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
    enable = 1'b1;
    slot(0, 7'h00, 1'b0, 1'b1, TD, 2, 16'h1234, 4'b0000);
    slot(1, 7'h78, 1'b0, 1'b0, 5, -1, 16'h0, 4'h0);

    // Asynchronous reset mid-slot with a write pending.
    rst = 1'b1;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    chk("async_rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("async_rst_fs", {31'd0, frame_start}, 32'd0);
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
    cyc(4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;

    // Active data was cleared: digit 0 shows 0 with dp dark.
    slot(0, 7'h40, 1'b1, 1'b1, TD, -1, 16'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
